// File: rtl/cellram_async_ctrl.sv
// Asynchronous-mode CellularRAM sequencer: one single-word read or write per request, all memory pins registered.
// One access every ACCESS_CYCLES+RECOVER_CYCLES+3 cycles, done in its first recover cycle; req is ignored (not queued) while ready=0.
module cellram_async_ctrl #(
  parameter int ACCESS_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic [22:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        done,
  output logic [22:0] mem_addr,
  inout  wire  [15:0] mem_dq,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic        mem_adv_n,
  output logic        mem_cre,
  output logic        mem_clk
);

  localparam int AW = $clog2(ACCESS_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RECOVER} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [22:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d;
  logic          ub_n_q, ub_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic          busy_d;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    rec_cnt_d = rec_cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          we_d    = we;
          be_d    = be;
          wdata_d = wdata;
          addr_d  = addr;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        acc_cnt_d = AW'(ACCESS_CYCLES);
      end
      ACCESS: begin
        // Capture on the edge that ends the last strobe cycle, while oe_n is still low.
        if (acc_cnt_q == AW'(1)) begin
          state_d = HOLD;
          if (!we_q) rdata_d = mem_dq;
        end else begin
          acc_cnt_d = acc_cnt_q - AW'(1);
        end
      end
      HOLD: begin
        state_d   = RECOVER;
        rec_cnt_d = RW'(RECOVER_CYCLES);
        done_d    = 1'b1;
      end
      RECOVER: begin
        if (rec_cnt_q == RW'(1)) state_d = IDLE;
        else                     rec_cnt_d = rec_cnt_q - RW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Pin values are decoded from the next state so every pin comes straight from a flop.
    busy_d  = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
    ce_n_d  = !busy_d;
    oe_n_d  = !((state_d == ACCESS) && !we_d);
    we_n_d  = !((state_d == ACCESS) && we_d);
    lb_n_d  = !(busy_d && be_d[0]);
    ub_n_d  = !(busy_d && be_d[1]);
    dq_oe_d = busy_d && we_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      rec_cnt_q <= '0;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      addr_q    <= 23'h000000;
      done_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      rec_cnt_q <= rec_cnt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      lb_n_q    <= lb_n_d;
      ub_n_q    <= ub_n_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign mem_dq    = dq_oe_q ? wdata_q : {16{1'bz}};
  assign rdata     = rdata_q;
  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_lb_n  = lb_n_q;
  assign mem_ub_n  = ub_n_q;
  assign mem_adv_n = 1'b0;
  assign mem_cre   = 1'b0;
  assign mem_clk   = 1'b0;

endmodule

// File: tb/tb_cellram_async_ctrl.sv
// Directed bench for cellram_async_ctrl against a small byte-laned async RAM model.
// Per-access strobe traces are compared against the expected cycle windows.
module tb_cellram_async_ctrl;

  localparam int A = 4;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [22:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        done;
  logic [22:0] mem_addr;
  wire  [15:0] mem_dq;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
  logic        mem_adv_n, mem_cre, mem_clk;

  int nchk = 0;
  int nerr = 0;
  int viol = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  cellram_async_ctrl #(.ACCESS_CYCLES(A), .RECOVER_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .done(done), .mem_addr(mem_addr), .mem_dq(mem_dq),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_lb_n(mem_lb_n),
    .mem_ub_n(mem_ub_n), .mem_adv_n(mem_adv_n), .mem_cre(mem_cre), .mem_clk(mem_clk)
  );

  // Sparse RAM: only the handful of addresses the test touches map to distinct slots.
  function automatic logic [2:0] ridx(input logic [22:0] a);
    return {a[22], a[5:4]};
  endfunction

  logic [15:0] ram [8];

  assign mem_dq = (!mem_ce_n && !mem_oe_n) ? ram[ridx(mem_addr)] : {16{1'bz}};

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 16'h0000;
    ram[ridx(23'h000000)] = 16'h5A5A;
    ram[ridx(23'h000030)] = 16'h7777;
    forever begin
      @(posedge mem_we_n);
      if (reset && !mem_ce_n) begin
        if (!mem_lb_n) ram[ridx(mem_addr)][7:0]  = mem_dq[7:0];
        if (!mem_ub_n) ram[ridx(mem_addr)][15:8] = mem_dq[15:8];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!mem_oe_n && !mem_we_n) viol++;
      if (dut.dq_oe_q && !mem_oe_n) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(ready), 32'd1);
  endtask

  task automatic run_access(input string tag, input logic w, input logic [1:0] b,
                            input logic [22:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
    logic [9:0]  t_ce, t_oe, t_we, t_dq, t_done, t_rdy, t_lb, t_ub;
    logic [9:0]  e_ce, e_oe, e_we, e_dq, e_done, e_rdy, e_lb, e_ub;
    logic [15:0] dq1, dq6, rd6;
    logic [22:0] ma3;
    bit          act, stb;
    wait_ready(tag);
    if (!ready) return;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    // Inputs are don't-care while busy; scramble them to prove they are not re-sampled.
    req = 1'b0; we = ~w; be = ~b; addr = ~a; wdata = ~d;
    {t_ce, t_oe, t_we, t_dq, t_done, t_rdy, t_lb, t_ub} = '0;
    {e_ce, e_oe, e_we, e_dq, e_done, e_rdy, e_lb, e_ub} = '0;
    dq1 = '0; dq6 = '0; rd6 = '0; ma3 = '0;
    for (int k = 1; k <= 9; k++) begin
      t_ce[k] = mem_ce_n;  t_oe[k] = mem_oe_n;  t_we[k] = mem_we_n;  t_dq[k] = dut.dq_oe_q;
      t_done[k] = done;    t_rdy[k] = ready;    t_lb[k] = mem_lb_n;  t_ub[k] = mem_ub_n;
      if (k == 1) dq1 = mem_dq;
      if (k == 3) ma3 = mem_addr;
      if (k == 6) begin dq6 = mem_dq; rd6 = rdata; end
      act = (k >= 1) && (k <= A + 2);
      stb = (k >= 2) && (k <= A + 1);
      e_ce[k] = !act;            e_oe[k] = !(stb && !w);   e_we[k] = !(stb && w);
      e_dq[k] = act && w;        e_done[k] = (k == A + 3); e_rdy[k] = (k >= A + R + 3);
      e_lb[k] = !(act && b[0]);  e_ub[k] = !(act && b[1]);
      if (k < 9) @(negedge clk);
    end
    chk({tag, " ce_n trace"},  32'(t_ce),   32'(e_ce));
    chk({tag, " oe_n trace"},  32'(t_oe),   32'(e_oe));
    chk({tag, " we_n trace"},  32'(t_we),   32'(e_we));
    chk({tag, " dq drive"},    32'(t_dq),   32'(e_dq));
    chk({tag, " done trace"},  32'(t_done), 32'(e_done));
    chk({tag, " ready trace"}, 32'(t_rdy),  32'(e_rdy));
    chk({tag, " lb_n trace"},  32'(t_lb),   32'(e_lb));
    chk({tag, " ub_n trace"},  32'(t_ub),   32'(e_ub));
    chk({tag, " mem_addr"},    32'(ma3),    32'(a));
    chk({tag, " mem_addr hold"}, 32'(mem_addr), 32'(a));
    chk({tag, " rdata c6"},    32'(rd6),    32'(exp_rd));
    chk({tag, " rdata c9"},    32'(rdata),  32'(exp_rd));
    if (w) begin
      chk({tag, " dq setup"}, 32'(dq1), 32'(d));
      chk({tag, " dq hold"},  32'(dq6), 32'(d));
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  be;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [19:0] s_rdy, s_done, s_ce, s_fall;
    int          dseen;

    vecs[0]  = '{1'b0, 2'b11, 23'h000000, 16'h0000, 16'h5A5A};
    vecs[1]  = '{1'b1, 2'b11, 23'h000010, 16'hA5C3, 16'h5A5A};
    vecs[2]  = '{1'b0, 2'b11, 23'h000010, 16'h0000, 16'hA5C3};
    vecs[3]  = '{1'b1, 2'b11, 23'h7FFFFF, 16'h1234, 16'hA5C3};
    vecs[4]  = '{1'b1, 2'b01, 23'h7FFFFF, 16'hFF00, 16'hA5C3};
    vecs[5]  = '{1'b0, 2'b11, 23'h7FFFFF, 16'h0000, 16'h1200};
    vecs[6]  = '{1'b1, 2'b11, 23'h000020, 16'hBEEF, 16'h1200};
    vecs[7]  = '{1'b1, 2'b00, 23'h000030, 16'h1111, 16'h1200};
    vecs[8]  = '{1'b0, 2'b11, 23'h000030, 16'h0000, 16'h7777};
    vecs[9]  = '{1'b1, 2'b10, 23'h000010, 16'h9900, 16'h7777};
    vecs[10] = '{1'b0, 2'b11, 23'h000010, 16'h0000, 16'h99C3};

    reset = 1'b0; req = 1'b1; we = 1'b1; be = 2'b11; addr = 23'h123456; wdata = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("reset ready",    32'(ready),    32'd1);
    chk("reset done",     32'(done),     32'd0);
    chk("reset rdata",    32'(rdata),    32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset strobes",  32'({mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}), 32'h1F);
    chk("reset dq drive", 32'(dut.dq_oe_q), 32'd0);
    chk("const pins",     32'({mem_adv_n, mem_cre, mem_clk}), 32'd0);
    req = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++)
      run_access($sformatf("v%0d", i), vecs[i].w, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // req held high: only cycles 0 and 9 may accept; req drops after cycle 17 so cycle 18 cannot.
    wait_ready("hold");
    s_rdy = '0; s_done = '0; s_ce = '0; s_fall = '0;
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 23'h000020;
    for (int k = 0; k < 20; k++) begin
      s_rdy[k] = ready; s_done[k] = done; s_ce[k] = mem_ce_n;
      if (k > 0 && s_ce[k-1] && !s_ce[k]) s_fall[k] = 1'b1;
      if (k == 17) req = 1'b0;
      @(negedge clk);
    end
    chk("hold accepts", 32'(s_fall), 32'h00402);
    chk("hold done",    32'(s_done), 32'h10080);
    chk("hold ready",   32'(s_rdy),  32'hC0201);
    chk("hold rdata",   32'(rdata),  32'hBEEF);

    // Reset asserted during cycle 3 of a write aborts it at the next edge.
    wait_ready("abort");
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 23'h000030; wdata = 16'h3C3C;
    repeat (3) begin
      @(negedge clk);
      req = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort ce_n",  32'(mem_ce_n),     32'd1);
    chk("abort we_n",  32'(mem_we_n),     32'd1);
    chk("abort dq",    32'(dut.dq_oe_q),  32'd0);
    chk("abort ready", 32'(ready),        32'd1);
    chk("abort done",  32'(done),         32'd0);
    chk("abort rdata", 32'(rdata),        32'd0);
    reset = 1'b1;
    dseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("abort no done", 32'(dseen), 32'd0);
    run_access("after abort", 1'b0, 2'b11, 23'h000030, 16'h0000, 16'h7777);

    chk("strobe overlap or dq contention", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
